// File: rtl/symbol_period_if.sv
// Handshake and display bundle between the play-period stage and its neighbours.
// The master side drives start/magic/levelComplete. The slave side (the stage itself) drives the rest.
interface symbol_period_if;
  logic       startLevel;
  logic [3:0] magicSymbol;
  logic       levelComplete;
  logic       postSig;
  logic [7:0] magicSymbolCount;
  logic [7:0] symbolSeg;
  logic       running;

  modport master (
    output startLevel, magicSymbol, levelComplete,
    input  postSig, magicSymbolCount, symbolSeg, running
  );

  modport slave (
    input  startLevel, magicSymbol, levelComplete,
    output postSig, magicSymbolCount, symbolSeg, running
  );
endinterface

// File: rtl/symbol_period.sv
// Play-period stage: shows a pseudo-random digit on one 7-segment display and counts
// magic-symbol hits. On expiry it pulses postSig and holds the count until levelComplete.
module symbol_period #(
  parameter int unsigned CYCLES_PER_SEC = 100000000,
  parameter int unsigned SYMBOL_CYCLES  = 50000000,
  parameter int unsigned PLAY_SECONDS   = 10,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic           Clk100M,
  input  logic           Rst,
  symbol_period_if.slave bus
);

  localparam int unsigned SecW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam int unsigned SymW = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam logic [SecW-1:0] SecMax   = SecW'(CYCLES_PER_SEC - 1);
  localparam logic [SymW-1:0] SymMax   = SymW'(SYMBOL_CYCLES - 1);
  localparam logic [7:0]      SegBlank = 8'hFF;
  localparam logic [7:0]      CountMax = 8'd99;

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e          r_state, w_state_nxt;
  logic [15:0]     r_lfsr, w_lfsr_nxt;
  logic [SecW-1:0] r_sec_cnt, w_sec_cnt_nxt;
  logic [SymW-1:0] r_sym_cnt, w_sym_cnt_nxt;
  logic [7:0]      r_secs_left, w_secs_left_nxt;
  logic [3:0]      r_magic, w_magic_nxt;
  logic [7:0]      r_count, w_count_nxt;
  logic [7:0]      r_seg, w_seg_nxt;
  logic            r_post, w_post_nxt;
  logic [3:0]      w_sym_raw, w_sym_val;
  logic            w_hit;

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_encode = 8'hC0;
      4'd1:    seg_encode = 8'hF9;
      4'd2:    seg_encode = 8'hA4;
      4'd3:    seg_encode = 8'hB0;
      4'd4:    seg_encode = 8'h99;
      4'd5:    seg_encode = 8'h92;
      4'd6:    seg_encode = 8'h82;
      4'd7:    seg_encode = 8'hD8;
      4'd8:    seg_encode = 8'h80;
      4'd9:    seg_encode = 8'h90;
      default: seg_encode = 8'hFF;
    endcase
  endfunction

  // Fibonacci taps 16,14,13,11; free-running in every state
  assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_sym_raw  = r_lfsr[3:0];
  assign w_sym_val  = (w_sym_raw >= 4'd10) ? w_sym_raw - 4'd10 : w_sym_raw;

  always_comb begin
    w_state_nxt     = r_state;
    w_sec_cnt_nxt   = r_sec_cnt;
    w_sym_cnt_nxt   = r_sym_cnt;
    w_secs_left_nxt = r_secs_left;
    w_magic_nxt     = r_magic;
    w_count_nxt     = r_count;
    w_seg_nxt       = r_seg;
    w_post_nxt      = 1'b0;
    w_hit           = 1'b0;
    case (r_state)
      StIdle: begin
        w_sec_cnt_nxt = '0;
        w_sym_cnt_nxt = '0;
        w_seg_nxt     = SegBlank;
        if (bus.startLevel) begin
          w_magic_nxt     = bus.magicSymbol;
          w_count_nxt     = '0;
          w_secs_left_nxt = 8'(PLAY_SECONDS);
          w_state_nxt     = StRun;
        end
      end
      StRun: begin
        w_hit         = (r_sym_cnt == '0) && (w_sym_val == r_magic);
        w_sym_cnt_nxt = (r_sym_cnt == SymMax) ? '0 : r_sym_cnt + SymW'(1);
        if (r_sym_cnt == '0) w_seg_nxt = seg_encode(w_sym_val);
        if (w_hit && (r_count < CountMax)) w_count_nxt = r_count + 8'd1;
        if (r_sec_cnt == SecMax) begin
          w_sec_cnt_nxt   = '0;
          w_secs_left_nxt = r_secs_left - 8'd1;
          // Last second wrapping: a draw on this cycle is still counted, but the display blanks
          if (r_secs_left == 8'd1) begin
            w_state_nxt = StHold;
            w_post_nxt  = 1'b1;
            w_seg_nxt   = SegBlank;
          end
        end else begin
          w_sec_cnt_nxt = r_sec_cnt + SecW'(1);
        end
      end
      StHold: begin
        w_sec_cnt_nxt = '0;
        w_sym_cnt_nxt = '0;
        w_seg_nxt     = SegBlank;
        if (bus.levelComplete) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge Clk100M or posedge Rst) begin
    if (Rst) begin
      r_state     <= StIdle;
      r_lfsr      <= LFSR_SEED;
      r_sec_cnt   <= '0;
      r_sym_cnt   <= '0;
      r_secs_left <= '0;
      r_magic     <= '0;
      r_count     <= '0;
      r_seg       <= SegBlank;
      r_post      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_sec_cnt   <= w_sec_cnt_nxt;
      r_sym_cnt   <= w_sym_cnt_nxt;
      r_secs_left <= w_secs_left_nxt;
      r_magic     <= w_magic_nxt;
      r_count     <= w_count_nxt;
      r_seg       <= w_seg_nxt;
      r_post      <= w_post_nxt;
    end
  end

  assign bus.postSig          = r_post;
  assign bus.magicSymbolCount = r_count;
  assign bus.symbolSeg        = r_seg;
  assign bus.running          = (r_state == StRun);

endmodule
